// File: rtl/sram_arbiter_ctrl_if.sv
// Avalon-style requester bundle for one port of sram_arbiter_ctrl.
//   master : the requester side (drives command, receives stall and read data)
//   slave  : the arbiter side (receives command, drives stall and read data)
// Signals:
//   address        word address
//   byteenable     byte lanes, bit0 = low byte
//   read/write     command strobes (write wins when both are high)
//   writedata      write data
//   waitrequest    stall; a command is taken when (read|write) & !waitrequest
//   readdata       last read result for this port
//   readdatavalid  one-cycle strobe marking a completed read
interface sram_arbiter_ctrl_if #(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 16
);
  logic [ADDR_W-1:0]   address;
  logic [DATA_W/8-1:0] byteenable;
  logic                read;
  logic                write;
  logic [DATA_W-1:0]   writedata;
  logic                waitrequest;
  logic [DATA_W-1:0]   readdata;
  logic                readdatavalid;

  modport master (
    output address, byteenable, read, write, writedata,
    input  waitrequest, readdata, readdatavalid
  );

  modport slave (
    input  address, byteenable, read, write, writedata,
    output waitrequest, readdata, readdatavalid
  );
endinterface

// File: rtl/sram_arbiter_ctrl.sv
// Two-port round-robin arbiter and access sequencer for an asynchronous
// 16-bit SRAM. One access runs at a time: IDLE (accept) -> ACCESS for
// WAIT_CYCLES clocks -> RECOVER for one clock -> IDLE.
// Ports:
//   clk, reset        system clock, synchronous active-high reset
//   m0, m1            requester ports (m0 = CPU data path, m1 = streaming client)
//   sram_ADDR         registered SRAM word address
//   sram_DQ_o/_oe/_i  split data bus; the tristate lives at the board top level
//   sram_CE_N, sram_OE_N, sram_WE_N, sram_LB_N, sram_UB_N
//                     registered active-low SRAM strobes
module sram_arbiter_ctrl #(
  parameter int ADDR_W      = 20,
  parameter int DATA_W      = 16,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  sram_arbiter_ctrl_if.slave m0,
  sram_arbiter_ctrl_if.slave m1,
  output logic [ADDR_W-1:0] sram_ADDR,
  output logic [DATA_W-1:0] sram_DQ_o,
  output logic              sram_DQ_oe,
  input  logic [DATA_W-1:0] sram_DQ_i,
  output logic              sram_CE_N,
  output logic              sram_OE_N,
  output logic              sram_WE_N,
  output logic              sram_LB_N,
  output logic              sram_UB_N
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ACCESS  = 2'd1,
    S_RECOVER = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [3:0] r_wcnt;
  logic       r_last_grant;
  logic       r_wr;
  logic       r_port;

  logic              w_req0;
  logic              w_req1;
  logic              w_gnt0;
  logic              w_gnt1;
  logic              w_accept;
  logic              w_sel_wr;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [1:0]        w_sel_be;
  logic [DATA_W-1:0] w_sel_data;

  // Round-robin pick: a lone requester wins; on a tie the port that did not
  // win last time is chosen.
  always_comb begin
    w_req0     = m0.read | m0.write;
    w_req1     = m1.read | m1.write;
    w_gnt1     = w_req1 & (~w_req0 | ~r_last_grant);
    w_gnt0     = w_req0 & ~w_gnt1;
    w_sel_wr   = w_gnt1 ? m1.write      : m0.write;
    w_sel_addr = w_gnt1 ? m1.address    : m0.address;
    w_sel_be   = w_gnt1 ? m1.byteenable : m0.byteenable;
    w_sel_data = w_gnt1 ? m1.writedata  : m0.writedata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next         = r_state;
    w_accept       = 1'b0;
    m0.waitrequest = 1'b1;
    m1.waitrequest = 1'b1;
    case (r_state)
      S_IDLE: begin
        if (!reset && (w_req0 || w_req1)) begin
          w_accept       = 1'b1;
          w_next         = S_ACCESS;
          m0.waitrequest = ~w_gnt0;
          m1.waitrequest = ~w_gnt1;
        end
      end
      S_ACCESS: begin
        if (r_wcnt == 4'd0) begin
          w_next = S_RECOVER;
        end
      end
      S_RECOVER: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Strobes are loaded on the edge that enters a phase so that every SRAM
  // pin comes straight from a flop.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wcnt           <= 4'd0;
      r_last_grant     <= 1'b1;
      r_wr             <= 1'b0;
      r_port           <= 1'b0;
      sram_ADDR        <= '0;
      sram_DQ_o        <= '0;
      sram_DQ_oe       <= 1'b0;
      sram_CE_N        <= 1'b1;
      sram_OE_N        <= 1'b1;
      sram_WE_N        <= 1'b1;
      sram_LB_N        <= 1'b1;
      sram_UB_N        <= 1'b1;
      m0.readdata      <= '0;
      m1.readdata      <= '0;
      m0.readdatavalid <= 1'b0;
      m1.readdatavalid <= 1'b0;
    end else begin
      m0.readdatavalid <= 1'b0;
      m1.readdatavalid <= 1'b0;
      if (w_accept) begin
        r_last_grant <= w_gnt1;
        r_port       <= w_gnt1;
        r_wr         <= w_sel_wr;
        r_wcnt       <= 4'(WAIT_CYCLES - 1);
        sram_ADDR    <= w_sel_addr;
        if (w_sel_wr) begin
          sram_DQ_o <= w_sel_data;
        end
        sram_CE_N  <= 1'b0;
        sram_OE_N  <= w_sel_wr;
        sram_WE_N  <= ~w_sel_wr;
        sram_DQ_oe <= w_sel_wr;
        sram_LB_N  <= ~w_sel_be[0];
        sram_UB_N  <= ~w_sel_be[1];
      end else if (r_state == S_ACCESS) begin
        if (r_wcnt != 4'd0) begin
          r_wcnt <= r_wcnt - 4'd1;
        end else begin
          // Last ACCESS clock: release the bus for the recovery cycle and
          // take the read data while OE_N is still low.
          sram_CE_N  <= 1'b1;
          sram_OE_N  <= 1'b1;
          sram_WE_N  <= 1'b1;
          sram_LB_N  <= 1'b1;
          sram_UB_N  <= 1'b1;
          sram_DQ_oe <= 1'b0;
          if (!r_wr) begin
            if (r_port) begin
              m1.readdata      <= sram_DQ_i;
              m1.readdatavalid <= 1'b1;
            end else begin
              m0.readdata      <= sram_DQ_i;
              m0.readdatavalid <= 1'b1;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_sram_arbiter_ctrl.sv
module tb_sram_arbiter_ctrl;
  localparam int AW = 20;
  localparam int DW = 16;
  localparam int WA = 2;
  localparam int WB = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a;
  logic rst_b;

  sram_arbiter_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) a0 ();
  sram_arbiter_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) a1 ();
  sram_arbiter_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) b0 ();
  sram_arbiter_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) b1 ();

  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_dqo, a_dqi, b_dqo, b_dqi;
  logic a_dqoe, a_ce, a_oe, a_we, a_lb, a_ub;
  logic b_dqoe, b_ce, b_oe, b_we, b_lb, b_ub;

  sram_arbiter_ctrl #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(WA)) dut_a (
    .clk(clk), .reset(rst_a), .m0(a0), .m1(a1),
    .sram_ADDR(a_addr), .sram_DQ_o(a_dqo), .sram_DQ_oe(a_dqoe), .sram_DQ_i(a_dqi),
    .sram_CE_N(a_ce), .sram_OE_N(a_oe), .sram_WE_N(a_we), .sram_LB_N(a_lb), .sram_UB_N(a_ub)
  );

  sram_arbiter_ctrl #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(WB)) dut_b (
    .clk(clk), .reset(rst_b), .m0(b0), .m1(b1),
    .sram_ADDR(b_addr), .sram_DQ_o(b_dqo), .sram_DQ_oe(b_dqoe), .sram_DQ_i(b_dqi),
    .sram_CE_N(b_ce), .sram_OE_N(b_oe), .sram_WE_N(b_we), .sram_LB_N(b_lb), .sram_UB_N(b_ub)
  );

  // Asynchronous SRAM behaviour for DUT A (addresses live in 0x12340..0x1237F).
  logic [15:0] mem_a [0:63] = '{default: 16'h0000};
  always @(posedge clk) begin
    if (!a_ce && !a_we) begin
      if (!a_lb) mem_a[a_addr[5:0]][7:0]  <= a_dqo[7:0];
      if (!a_ub) mem_a[a_addr[5:0]][15:8] <= a_dqo[15:8];
    end
  end
  assign a_dqi = (!a_ce && !a_oe) ? mem_a[a_addr[5:0]] : 16'hDEAD;
  assign b_dqi = 16'h0000;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  // Reference model state (transaction level)
  bit          m_busy = 1'b0;
  int          m_t = 0;
  bit          m_wr = 1'b0;
  bit          m_port = 1'b0;
  bit          m_lg = 1'b1;
  logic [19:0] m_addr = '0;
  logic [1:0]  m_be = '0;
  logic [15:0] m_data = '0;
  logic [15:0] m_rval = '0;
  logic [19:0] m_pin_addr = '0;
  logic [15:0] m_pin_dq = '0;
  logic [15:0] m_rd [0:1] = '{16'h0, 16'h0};
  logic [15:0] refmem [0:63] = '{default: 16'h0000};
  bit          grants[$];

  // Probes for the directed checks
  bit a_acc0, a_acc1;
  int acc_cyc = 0, rdv0_cyc = 0;
  int we_low_cnt = 0, oe_low_cnt = 0, lb_only_cnt = 0, rdv0_cnt = 0, rdv1_cnt = 0;
  bit logb = 1'b0;
  logic b_ce_q[$], b_we_q[$], b_wr_q[$];

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  task automatic cycle_check();
    int off;
    bit act, rec, idle, r0, r1, g0, g1;
    off  = cyc - m_t;
    act  = m_busy && (off >= 1) && (off <= WA);
    rec  = m_busy && (off == WA + 1);
    idle = !m_busy;
    if (rec && !m_wr) m_rd[m_port] = m_rval;
    r0 = a0.read | a0.write;
    r1 = a1.read | a1.write;
    g1 = r1 && (!r0 || !m_lg);
    g0 = r0 && !g1;

    chk("CE_N", a_ce, !act);
    chk("OE_N", a_oe, !(act && !m_wr));
    chk("WE_N", a_we, !(act && m_wr));
    chk("LB_N", a_lb, !(act && m_be[0]));
    chk("UB_N", a_ub, !(act && m_be[1]));
    chk("DQ_oe", a_dqoe, act && m_wr);
    chk("ADDR", a_addr, m_pin_addr);
    chk("DQ_o", a_dqo, m_pin_dq);
    chk("m0_waitrequest", a0.waitrequest, !(idle && !rst_a && g0));
    chk("m1_waitrequest", a1.waitrequest, !(idle && !rst_a && g1));
    chk("m0_readdatavalid", a0.readdatavalid, rec && !m_wr && !m_port);
    chk("m1_readdatavalid", a1.readdatavalid, rec && !m_wr && m_port);
    chk("m0_readdata", a0.readdata, m_rd[0]);
    chk("m1_readdata", a1.readdata, m_rd[1]);

    a_acc0 = r0 && !a0.waitrequest && !rst_a;
    a_acc1 = r1 && !a1.waitrequest && !rst_a;
    if (a_acc0 || a_acc1) acc_cyc = cyc;
    if (!a_we && a_dqoe) we_low_cnt++;
    if (!a_oe) oe_low_cnt++;
    if (!a_ce && !a_lb && a_ub) lb_only_cnt++;
    if (a0.readdatavalid) begin rdv0_cnt++; rdv0_cyc = cyc; end
    if (a1.readdatavalid) rdv1_cnt++;
    if (logb) begin
      b_ce_q.push_back(b_ce);
      b_we_q.push_back(b_we);
      b_wr_q.push_back(b0.waitrequest);
    end

    if (rst_a) begin
      m_busy = 1'b0; m_lg = 1'b1; m_pin_addr = '0; m_pin_dq = '0;
      m_rd[0] = '0; m_rd[1] = '0;
    end else if (idle && (r0 || r1)) begin
      m_busy = 1'b1; m_t = cyc; m_port = g1; m_lg = g1;
      grants.push_back(g1);
      if (g1) begin
        m_wr = a1.write; m_addr = a1.address; m_be = a1.byteenable; m_data = a1.writedata;
      end else begin
        m_wr = a0.write; m_addr = a0.address; m_be = a0.byteenable; m_data = a0.writedata;
      end
      m_pin_addr = m_addr;
      if (m_wr) begin
        m_pin_dq = m_data;
        if (m_be[0]) refmem[m_addr[5:0]][7:0]  = m_data[7:0];
        if (m_be[1]) refmem[m_addr[5:0]][15:8] = m_data[15:8];
      end else begin
        m_rval = refmem[m_addr[5:0]];
      end
    end else if (rec) begin
      m_busy = 1'b0;
    end
    cyc++;
  endtask

  task automatic tick();
    @(negedge clk);
    cycle_check();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input bit p, input bit rd, input bit wr, input logic [19:0] ad,
                         input logic [1:0] be, input logic [15:0] d);
    if (p) begin
      a1.read = rd; a1.write = wr; a1.address = ad; a1.byteenable = be; a1.writedata = d;
    end else begin
      a0.read = rd; a0.write = wr; a0.address = ad; a0.byteenable = be; a0.writedata = d;
    end
  endtask

  task automatic issue_a(input bit p, input bit rd, input bit wr, input logic [19:0] ad,
                         input logic [1:0] be, input logic [15:0] d);
    bit done;
    done = 1'b0;
    drive_a(p, rd, wr, ad, be, d);
    for (int i = 0; i < 40 && !done; i++) begin
      tick();
      done = p ? a_acc1 : a_acc0;
    end
    if (!done) chk("accept_timeout", 32'd0, 32'd1);
    drive_a(p, 1'b0, 1'b0, '0, '0, '0);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    bit pend [0:1];
    bit got;
    int kind;
    rst_a = 1'b1; rst_b = 1'b1;
    drive_a(1'b0, 1'b0, 1'b0, '0, '0, '0);
    drive_a(1'b1, 1'b0, 1'b0, '0, '0, '0);
    b0.read = 1'b0; b0.write = 1'b0; b0.address = '0; b0.byteenable = '0; b0.writedata = '0;
    b1.read = 1'b0; b1.write = 1'b0; b1.address = '0; b1.byteenable = '0; b1.writedata = '0;
    ticks(2);
    chk("rst_CE_N", a_ce, 1'b1);
    chk("rst_WE_N", a_we, 1'b1);
    chk("rst_DQ_oe", a_dqoe, 1'b0);
    chk("rst_ADDR", a_addr, 20'h0);
    chk("rst_m0_readdatavalid", a0.readdatavalid, 1'b0);
    rst_a = 1'b0; rst_b = 1'b0;
    tick();

    // Full-word write then read on port 0
    we_low_cnt = 0;
    issue_a(1'b0, 1'b0, 1'b1, 20'h12345, 2'b11, 16'hBEEF);
    ticks(4);
    chk("p1_we_low_cycles", we_low_cnt, 2);
    rdv0_cnt = 0;
    issue_a(1'b0, 1'b1, 1'b0, 20'h12345, 2'b11, 16'h0000);
    ticks(4);
    chk("p1_read_latency", rdv0_cyc - acc_cyc, 3);
    chk("p1_rdv_count", rdv0_cnt, 1);
    chk("p1_readdata", a0.readdata, 16'hBEEF);

    // Low-byte write merges into existing word
    issue_a(1'b0, 1'b0, 1'b1, 20'h12350, 2'b11, 16'h1234);
    ticks(4);
    lb_only_cnt = 0;
    issue_a(1'b0, 1'b0, 1'b1, 20'h12350, 2'b01, 16'hAA55);
    ticks(4);
    chk("p2_lb_only_cycles", lb_only_cnt, 2);
    issue_a(1'b0, 1'b1, 1'b0, 20'h12350, 2'b11, 16'h0000);
    ticks(4);
    chk("p2_byte_merge", a0.readdata, 16'h1255);

    // Both ports reading continuously: grants alternate from port 0
    rst_a = 1'b1; tick(); rst_a = 1'b0;
    grants.delete(); rdv0_cnt = 0; rdv1_cnt = 0;
    drive_a(1'b0, 1'b1, 1'b0, 20'h12345, 2'b11, 16'h0);
    drive_a(1'b1, 1'b1, 1'b0, 20'h12350, 2'b11, 16'h0);
    for (int i = 0; i < 60 && grants.size() < 6; i++) tick();
    drive_a(1'b0, 1'b0, 1'b0, '0, '0, '0);
    drive_a(1'b1, 1'b0, 1'b0, '0, '0, '0);
    ticks(5);
    chk("p3_grant_count", grants.size(), 6);
    for (int i = 0; i < 6; i++) chk("p3_grant", grants[i], i % 2);
    chk("p3_rdv0_count", rdv0_cnt, 3);
    chk("p3_rdv1_count", rdv1_cnt, 3);
    chk("p3_m1_readdata", a1.readdata, 16'h1255);

    // Read+write together on port 1 performs a write only
    we_low_cnt = 0; oe_low_cnt = 0; rdv1_cnt = 0;
    issue_a(1'b1, 1'b1, 1'b1, 20'h12362, 2'b11, 16'hC0DE);
    ticks(4);
    chk("p4_we_low_cycles", we_low_cnt, 2);
    chk("p4_oe_low_cycles", oe_low_cnt, 0);
    chk("p4_no_rdv", rdv1_cnt, 0);

    // Reset during the ACCESS phase of a read
    rdv0_cnt = 0; rdv1_cnt = 0;
    issue_a(1'b0, 1'b1, 1'b0, 20'h12345, 2'b11, 16'h0);
    chk("p5_in_access", a_ce, 1'b0);
    rst_a = 1'b1;
    tick();
    chk("p5_CE_N", a_ce, 1'b1);
    chk("p5_OE_N", a_oe, 1'b1);
    chk("p5_WE_N", a_we, 1'b1);
    chk("p5_LB_UB_N", {a_lb, a_ub}, 2'b11);
    chk("p5_DQ_oe", a_dqoe, 1'b0);
    rst_a = 1'b0;
    ticks(2);
    chk("p5_no_rdv_after_reset", rdv0_cnt, 0);
    grants.delete();
    drive_a(1'b0, 1'b1, 1'b0, 20'h12362, 2'b11, 16'h0);
    drive_a(1'b1, 1'b1, 1'b0, 20'h12350, 2'b11, 16'h0);
    for (int i = 0; i < 10 && grants.size() < 1; i++) tick();
    drive_a(1'b0, 1'b0, 1'b0, '0, '0, '0);
    drive_a(1'b1, 1'b0, 1'b0, '0, '0, '0);
    ticks(5);
    chk("p5_first_grant", grants.size() > 0 ? grants[0] : 1'b1, 1'b0);
    chk("p5_rdv0_count", rdv0_cnt, 1);
    chk("p5_m0_readdata", a0.readdata, 16'hC0DE);

    // Randomized traffic from both ports
    pend[0] = 1'b0; pend[1] = 1'b0;
    for (int c = 0; c < 700; c++) begin
      for (int p = 0; p < 2; p++) begin
        if (!pend[p] && $urandom_range(0, 2) != 0) begin
          pend[p] = 1'b1;
          kind = $urandom_range(0, 3);
          drive_a(p[0], kind != 2, kind >= 2, 20'h12340 + 20'($urandom_range(0, 15)),
                  2'($urandom_range(0, 3)), 16'($urandom));
        end
      end
      tick();
      if (a_acc0) begin pend[0] = 1'b0; drive_a(1'b0, 1'b0, 1'b0, '0, '0, '0); end
      if (a_acc1) begin pend[1] = 1'b0; drive_a(1'b1, 1'b0, 1'b0, '0, '0, '0); end
    end
    drive_a(1'b0, 1'b0, 1'b0, '0, '0, '0);
    drive_a(1'b1, 1'b0, 1'b0, '0, '0, '0);
    ticks(6);

    // One-wait-state instance: back-to-back writes take 3 clocks each
    got = 1'b0;
    b0.write = 1'b1; b0.address = 20'h00001; b0.byteenable = 2'b11; b0.writedata = 16'h5A5A;
    logb = 1'b1;
    ticks(9);
    logb = 1'b0;
    b0.write = 1'b0;
    ticks(3);
    chk("b_log_len", b_ce_q.size(), 9);
    for (int k = 0; k < 9 && k < b_ce_q.size(); k++) begin
      chk("b_CE_N", b_ce_q[k], (k % 3) != 1);
      chk("b_WE_N", b_we_q[k], (k % 3) != 1);
      chk("b_m0_waitrequest", b_wr_q[k], (k % 3) != 0);
      if (b_we_q[k] == 1'b0) got = 1'b1;
    end
    chk("b_any_write", got, 1'b1);
    chk("b_no_rdv", b0.readdatavalid, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
